// File: rtl/if_stage.sv
// Instruction fetch stage: issues word fetches to a byte-serial memory controller
// and queues returned instructions with their PCs for the decode stage.
module if_stage #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_inst,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);
    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t           state, state_next;
    logic [31:0]      pc, pc_next;
    logic             mem_req_next;
    logic [31:0]      mem_addr_next;
    logic [31:0]      inst_q [QUEUE_DEPTH];
    logic [31:0]      pc_q   [QUEUE_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic             push, pop, room;
    logic [31:0]      jump_target;
    logic [31:0]      pc_inc;

    assign jump_target = jump_addr & ~32'h3;
    assign pc_inc      = pc + 32'd4;

    // FIFO head is presented combinationally; zeros when empty.
    assign id_valid = (count != '0);
    assign id_inst  = id_valid ? inst_q[rd_ptr] : 32'h0;
    assign id_pc    = id_valid ? pc_q[rd_ptr]   : 32'h0;

    // A redirect flushes the queue, so it overrides both push and pop.
    assign pop  = id_valid && !id_stall && !jump_en;
    assign push = (state == WAIT) && mem_valid && !jump_en;

    always_comb begin
        if (jump_en) begin
            count_next = '0;
        end else begin
            count_next = count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign room = (count_next < CNT_W'(QUEUE_DEPTH));

    // Next-state and request logic
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        mem_req_next  = mem_req;
        mem_addr_next = mem_addr;
        case (state)
            IDLE: begin
                if (jump_en) begin
                    pc_next = jump_target;
                end else if (room) begin
                    mem_req_next  = 1'b1;
                    mem_addr_next = pc;
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                if (jump_en && mem_valid) begin
                    pc_next      = jump_target;
                    mem_req_next = 1'b0;
                    state_next   = IDLE;
                end else if (jump_en) begin
                    // The controller cannot abort, so the request stays up until it answers.
                    pc_next    = jump_target;
                    state_next = DISCARD;
                end else if (mem_valid) begin
                    pc_next = pc_inc;
                    if (room) begin
                        mem_addr_next = pc_inc;
                    end else begin
                        mem_req_next = 1'b0;
                        state_next   = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (jump_en) begin
                    pc_next = jump_target;
                end
                if (mem_valid) begin
                    mem_req_next = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: begin
                mem_req_next = 1'b0;
                state_next   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            mem_req  <= mem_req_next;
            mem_addr <= mem_addr_next;
            count    <= count_next;
            if (jump_en) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                rd_ptr <= rd_ptr + PTR_W'(pop);
                wr_ptr <= wr_ptr + PTR_W'(push);
            end
        end
    end

    // Queue storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wr_ptr] <= mem_inst;
            pc_q[wr_ptr]   <= mem_addr;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a memory responder plus a transaction-level fetch model
// compared against the DUT every cycle, with directed scenarios and literal checks.
module tb_if_stage;
    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_inst;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    if_stage #(.QUEUE_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_inst  (mem_inst),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .id_stall  (id_stall),
        .id_valid  (id_valid),
        .id_inst   (id_inst),
        .id_pc     (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory responder state
    bit          mem_auto = 1'b1;
    bit          busy = 1'b0;
    int          wait_cnt = 0;
    int          mem_lat = 4;
    logic [31:0] word_ctr = 32'd1;
    bit          trig_en = 1'b0;
    logic [31:0] trig_addr = 32'h0;
    logic [31:0] trig_target = 32'h0;

    // observation logs
    logic [31:0] pop_pc[$];
    logic [31:0] pop_inst[$];
    logic [31:0] req_log[$];

    // model: queue of {inst, pc}, next PC, one outstanding fetch
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    bit          m_out;
    bit          m_wanted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pl(input int i);
        return (pop_pc.size() > i) ? pop_pc[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] il(input int i);
        return (pop_inst.size() > i) ? pop_inst[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] rl(input int i);
        return (req_log.size() > i) ? req_log[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pc     = 32'h0;
        m_addr   = 32'h0;
        m_out    = 1'b0;
        m_wanted = 1'b0;
    endtask

    task automatic clear_logs();
        pop_pc.delete();
        pop_inst.delete();
        req_log.delete();
        word_ctr = 32'd1;
    endtask

    // One clock: respond, compare, advance model; starts and ends just after negedge.
    task automatic cycle();
        bit          pop_m;
        bit          arrive;
        bit          push_m;
        bit          issue;
        logic [63:0] head;
        if (mem_auto) begin
            mem_valid = 1'b0;
            if (mem_req) begin
                if (!busy) begin
                    busy     = 1'b1;
                    wait_cnt = 0;
                    req_log.push_back(mem_addr);
                end
                wait_cnt++;
                if (wait_cnt >= mem_lat) begin
                    mem_valid = 1'b1;
                    mem_inst  = word_ctr * 32'h1111_1111;
                    word_ctr  = word_ctr + 32'd1;
                    busy      = 1'b0;
                end
            end
        end
        if (trig_en && mem_valid && mem_addr == trig_addr) begin
            jump_en   = 1'b1;
            jump_addr = trig_target;
            trig_en   = 1'b0;
        end
        #1;
        head = (m_q.size() != 0) ? m_q[0] : 64'h0;
        check("mem_req", {31'h0, mem_req}, {31'h0, m_out});
        if (m_out) check("mem_addr", mem_addr, m_addr);
        check("id_valid", {31'h0, id_valid}, {31'h0, (m_q.size() != 0)});
        check("id_pc", id_pc, head[31:0]);
        check("id_inst", id_inst, head[63:32]);
        if (id_valid && !id_stall && !jump_en) begin
            pop_pc.push_back(id_pc);
            pop_inst.push_back(id_inst);
        end
        pop_m  = (m_q.size() != 0) && !id_stall;
        arrive = m_out && mem_valid;
        push_m = arrive && m_wanted && !jump_en;
        if (jump_en) begin
            m_q.delete();
            m_pc = jump_addr & ~32'h3;
            if (m_out && !arrive) m_wanted = 1'b0;
        end else begin
            if (pop_m) void'(m_q.pop_front());
            if (push_m) begin
                m_q.push_back({mem_inst, m_addr});
                m_pc = m_pc + 32'd4;
            end
        end
        if (arrive) m_out = 1'b0;
        issue = !jump_en && !m_out && (m_q.size() < DEPTH) && (!arrive || push_m);
        if (issue) begin
            m_out    = 1'b1;
            m_wanted = 1'b1;
            m_addr   = m_pc;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            jump_en = 1'b0;
            cycle();
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        jump_en   = 1'b0;
        mem_valid = 1'b0;
        busy      = 1'b0;
        wait_cnt  = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_id_valid", {31'h0, id_valid}, 32'h0);
        model_reset();
        clear_logs();
        rst = 1'b1;
    endtask

    initial begin
        int n;
        rst       = 1'b0;
        mem_valid = 1'b0;
        mem_inst  = 32'h0;
        jump_en   = 1'b0;
        jump_addr = 32'h0;
        id_stall  = 1'b0;

        // 1: basic sequential fetch, 4-cycle latency
        do_reset();
        n = 0;
        while (pop_pc.size() < 3 && n < 60) begin run(1); n++; end
        check("t1_pc0", pl(0), 32'h0);
        check("t1_pc1", pl(1), 32'h4);
        check("t1_pc2", pl(2), 32'h8);
        check("t1_inst0", il(0), 32'h1111_1111);
        check("t1_inst1", il(1), 32'h2222_2222);
        check("t1_inst2", il(2), 32'h3333_3333);
        check("t1_req2", rl(2), 32'h8);

        // 2: stall fills the queue, then drains and resumes at 0x10
        do_reset();
        id_stall = 1'b1;
        run(30);
        check("t2_full_valid", {31'h0, id_valid}, 32'h1);
        check("t2_full_noreq", {31'h0, mem_req}, 32'h0);
        check("t2_full_head", id_pc, 32'h0);
        id_stall = 1'b0;
        run(4);
        check("t2_pops", pop_pc.size(), 32'd4);
        check("t2_pop3", pl(3), 32'hC);
        run(10);
        check("t2_req4", rl(4), 32'h10);
        check("t2_pop4", pl(4), 32'h10);
        check("t2_inst4", il(4), 32'h5555_5555);

        // 3: redirect while waiting on 0x8
        do_reset();
        id_stall = 1'b1;
        n = 0;
        while (!(mem_req && mem_addr == 32'h8) && n < 40) begin run(1); n++; end
        check("t3_reach", {31'h0, (mem_req && mem_addr == 32'h8)}, 32'h1);
        jump_en   = 1'b1;
        jump_addr = 32'h100;
        cycle();
        jump_en = 1'b0;
        check("t3_flushed", {31'h0, id_valid}, 32'h0);
        id_stall = 1'b0;
        run(20);
        check("t3_req", rl(3), 32'h100);
        check("t3_pop0", pl(0), 32'h100);
        check("t3_inst0", il(0), 32'h4444_4444);

        // 4: redirect in the same cycle as the 0x4 response, unaligned target
        do_reset();
        trig_en     = 1'b1;
        trig_addr   = 32'h4;
        trig_target = 32'h203;
        run(25);
        check("t4_fired", {31'h0, trig_en}, 32'h0);
        check("t4_pop0", pl(0), 32'h0);
        check("t4_pop1", pl(1), 32'h200);
        check("t4_inst1", il(1), 32'h3333_3333);
        check("t4_req2", rl(2), 32'h200);

        // 5: single-cycle memory, simultaneous push/pop with two entries, pointer wrap
        mem_lat = 1;
        do_reset();
        id_stall = 1'b1;
        run(3);
        id_stall = 1'b0;
        run(16);
        check("t5_npops", {31'h0, (pop_pc.size() >= 12)}, 32'h1);
        for (int i = 0; i < 12; i++) check("t5_seq", pl(i), 32'(i * 4));
        mem_lat = 4;

        // 6: asynchronous reset mid-fetch, then a late response is ignored
        do_reset();
        id_stall = 1'b1;
        n = 0;
        while (!(id_valid && mem_req) && n < 40) begin run(1); n++; end
        check("t6_reach", {31'h0, (id_valid && mem_req)}, 32'h1);
        #2 rst = 1'b0;
        #1;
        check("t6_async_req", {31'h0, mem_req}, 32'h0);
        check("t6_async_addr", mem_addr, 32'h0);
        check("t6_async_valid", {31'h0, id_valid}, 32'h0);
        check("t6_async_inst", id_inst, 32'h0);
        check("t6_async_pc", id_pc, 32'h0);
        mem_valid = 1'b0;
        busy      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        clear_logs();
        rst = 1'b1;
        mem_auto  = 1'b0;
        mem_valid = 1'b1;
        mem_inst  = 32'hDEAD_BEEF;
        cycle();
        mem_valid = 1'b0;
        mem_auto  = 1'b1;
        check("t6_late_req", {31'h0, mem_req}, 32'h1);
        check("t6_late_addr", mem_addr, 32'h0);
        check("t6_late_valid", {31'h0, id_valid}, 32'h0);
        id_stall = 1'b0;
        run(12);
        check("t6_req0", rl(0), 32'h0);
        check("t6_pop0", pl(0), 32'h0);
        check("t6_inst0", il(0), 32'h1111_1111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage between the PC/branch logic and decode. Drives word addresses to the byte-serial memory controller, waits for its completion pulse, and buffers fetched instructions with their PCs in a small FIFO that decode drains under a stall signal. Branch/jump redirects flush the FIFO and discard any in-flight fetch.

## Interface
- `QUEUE_DEPTH`, 4: FIFO entries; power of two, at least 2.
- `RESET_PC`, 32'h0: PC loaded at reset; bits [1:0] must be 0.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_req`  out  1  fetch request to the memory controller; held until `mem_valid`.
- `mem_addr`  out  32  word address of the pending fetch; stable while `mem_req`=1.
- `mem_valid`  in  1  one-cycle pulse: `mem_inst` holds the word for `mem_addr`.
- `mem_inst`  in  32  fetched instruction.
- `jump_en`  in  1  redirect request from execute.
- `jump_addr`  in  32  redirect target; bits [1:0] ignored and forced to 0.
- `id_stall`  in  1  decode cannot accept this cycle.
- `id_valid`  out  1  FIFO head is valid.
- `id_inst`  out  32  FIFO head instruction; 0 when empty.
- `id_pc`  out  32  FIFO head PC; 0 when empty.

## Operation
- State: `pc` (next address to fetch), FSM {IDLE, WAIT, DISCARD}, circular FIFO with rd/wr pointers of width log2(QUEUE_DEPTH) and a count of width log2(QUEUE_DEPTH)+1.
- Room: `count_next < QUEUE_DEPTH`, where `count_next` includes this cycle's push and pop. At most one fetch is outstanding, so the FIFO never overflows.
- IDLE: if there is room and no `jump_en`, assert `mem_req` and set `mem_addr`=`pc`, then go to WAIT.
- WAIT, with `mem_valid` and no `jump_en`:
  - Push {`mem_inst`, `mem_addr`} and set `pc` += 4, wrapping mod 2^32.
  - If room remains, keep `mem_req`=1 with `mem_addr`=new `pc` and stay in WAIT (back-to-back fetch).
  - Otherwise drop `mem_req` and go to IDLE.
- WAIT, with `jump_en` and no `mem_valid`:
  - Set `pc`=`jump_addr` and flush the FIFO.
  - Keep `mem_req`/`mem_addr` unchanged, because the controller cannot abort, and go to DISCARD.
- WAIT, with `jump_en` and `mem_valid` in the same cycle: drop the response, set `pc`=`jump_addr`, flush, drop `mem_req`, go to IDLE.
- DISCARD: on `mem_valid`, drop the data, drop `mem_req`, go to IDLE.
  - A further `jump_en` in DISCARD overwrites `pc` and flushes again; the state stays DISCARD unless `mem_valid` is also present.
- IDLE with `jump_en`: set `pc`=`jump_addr`, flush, stay IDLE; the fetch issues on the next cycle.
- Pop: when `id_valid`=1 and `id_stall`=0, advance rd at the edge. Simultaneous push and pop leave the count unchanged.
- Priority in any cycle: reset, then `jump_en` (flush beats push and pop), then push/pop.

## Timing
- Reset (`rst`=0, asynchronous):
  - Outputs: `mem_req`=0, `mem_addr`=`RESET_PC`, `id_valid`=0, `id_inst`=0, `id_pc`=0.
  - Internal: `pc`=`RESET_PC`, FSM=IDLE, pointers=0, count=0.
- First `mem_req` appears one cycle after reset release.
- `mem_req`, `mem_addr` and FSM are registered. `id_*` are combinational from the FIFO head.
- Fetch latency: `mem_valid` edge → `id_valid`=1 on the following cycle (data registered into the FIFO).
- After a redirect, the first new request is driven one cycle after the edge that leaves IDLE-with-jump, or one cycle after the discarded response in DISCARD.
- Pointer wrap: QUEUE_DEPTH-1 → 0.
- Full FIFO with `id_stall`=1: no request issued; the FSM holds IDLE.
- Reset asserted mid-fetch: everything clears immediately. A late `mem_valid` after reset release while IDLE is ignored.

## Test plan
- Reset then memory returns words 0x11111111, 0x22222222, … with 4-cycle latency, `id_stall`=0 → `id_pc` sequence 0x0, 0x4, 0x8 with matching `id_inst`; `mem_addr` steps by 4.
- `id_stall`=1 held: FIFO fills to 4 entries (PCs 0x0–0xC), then `mem_req` stays 0. Release stall → 4 pops in 4 cycles, then fetching resumes at 0x10.
- `jump_en`=1, `jump_addr`=0x100 while WAIT at 0x8 → FIFO empty next cycle, the 0x8 response is dropped, the next request is 0x100, and the first `id_pc` after the jump is 0x100.
- `jump_en` in the same cycle as `mem_valid` for 0x4 → 0x4 is never presented; the next request is `jump_addr`; `jump_addr`=0x203 produces `mem_addr`=0x200.
- Push and pop in the same cycle with count=2 → count stays 2 and the head advances; wrap exercised over 10+ entries.
- Drive `rst`=0 mid-WAIT between edges → outputs reach reset values without a clock edge; after release, the first request is `RESET_PC`.
